// File: rtl/fp32_pkg.sv
// Shared constants, FSM state type and operand-unpack helper for the fp32
// multiplier front end.
package fp32_pkg;

    localparam int BIAS      = 127;
    localparam int EXP_MAX   = 255;
    localparam int MANT_W    = 24;
    localparam int PROD_W    = 48;
    localparam int MUL_STEPS = 12;

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    // Subnormal operands flush to zero, so the hidden bit alone cannot carry them.
    function automatic logic [MANT_W-1:0] unpack_mant(input logic [31:0] x);
        return (x[30:23] != 8'd0) ? {1'b1, x[22:0]} : '0;
    endfunction

endpackage

// File: rtl/fp32_mul_norm_if.sv
// Operand/result bus of the fp32 multiplier front end; master is the producer
// of operands and consumer of results.
interface fp32_mul_norm_if;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] Mr_norm;
    logic [7:0]  Er_norm;
    logic        GRS;
    logic        sign_out;
    logic        zero_out;
    logic        inf_out;
    logic        nan_out;
    logic        overflow1;
    logic        underflow1;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output a_in, b_in, in_valid, out_ready,
        input  in_ready, Mr_norm, Er_norm, GRS, sign_out, zero_out, inf_out,
               nan_out, overflow1, underflow1, out_valid
    );

    modport slave (
        input  a_in, b_in, in_valid, out_ready,
        output in_ready, Mr_norm, Er_norm, GRS, sign_out, zero_out, inf_out,
               nan_out, overflow1, underflow1, out_valid
    );
endinterface

// File: rtl/mant_mul_seq.sv
// Radix-4 shift-add 24x24 multiplier: two multiplier bits retired per cycle,
// full 48-bit product, done_o held until the next start_i.
module mant_mul_seq
    import fp32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [MANT_W-1:0] mcand_i,
    input  logic [MANT_W-1:0] mplier_i,
    output logic              done_o,
    output logic [PROD_W-1:0] prod_o
);

    logic [PROD_W-1:0] mcand_q;
    logic [MANT_W-1:0] mplier_q;
    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] pp_d;
    logic [3:0]        cnt_q;
    logic              busy_q;
    logic              done_q;

    // mcand_q is pre-shifted each step, so the partial product is already aligned.
    always_comb begin
        pp_d = '0;
        if (mplier_q[0]) pp_d = pp_d + mcand_q;
        if (mplier_q[1]) pp_d = pp_d + {mcand_q[PROD_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q  <= {{(PROD_W-MANT_W){1'b0}}, mcand_i};
            mplier_q <= mplier_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
        end else if (busy_q) begin
            acc_q    <= acc_q + pp_d;
            mcand_q  <= {mcand_q[PROD_W-3:0], 2'b00};
            mplier_q <= {2'b00, mplier_q[MANT_W-1:2]};
            cnt_q    <= cnt_q + 4'd1;
            if (cnt_q == 4'(MUL_STEPS - 1)) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/fp32_mul_norm.sv
// fp32 multiply front end: classify operands, sequence the mantissa multiply,
// then normalize / denormalize and produce the round-to-nearest-even decision.
module fp32_mul_norm
    import fp32_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    fp32_mul_norm_if.slave bus
);

    state_t state_q;

    logic              in_ready_q, out_valid_q;
    logic [MANT_W-1:0] mr_q;
    logic [7:0]        er_q;
    logic              grs_q, sign_q, zero_q, inf_q, nan_q, ovf_q, unf_q;
    // operand-derived facts held across the multiply
    logic              sgn_l_q, zero_l_q, inf_l_q, nan_l_q;
    logic signed [9:0] exp_q;

    logic [7:0]        ea, eb;
    logic              fa_nz, fb_nz, nan_d, inf_d, zero_d, accept;
    logic signed [9:0] exp_d;
    logic              mul_done;
    logic [PROD_W-1:0] prod;

    assign ea     = bus.a_in[30:23];
    assign eb     = bus.b_in[30:23];
    assign fa_nz  = |bus.a_in[22:0];
    assign fb_nz  = |bus.b_in[22:0];
    assign accept = (state_q == IDLE) && bus.in_valid;

    always_comb begin
        nan_d  = (ea == 8'(EXP_MAX) && fa_nz) || (eb == 8'(EXP_MAX) && fb_nz) ||
                 ((ea == 8'(EXP_MAX) || eb == 8'(EXP_MAX)) && (ea == 8'd0 || eb == 8'd0));
        inf_d  = (ea == 8'(EXP_MAX) || eb == 8'(EXP_MAX)) && !nan_d;
        zero_d = (ea == 8'd0 || eb == 8'd0) && !nan_d && !inf_d;
        exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed(10'(BIAS));
    end

    mant_mul_seq u_mul (
        .clk      (clk),
        .rst      (rst),
        .start_i  (accept),
        .mcand_i  (unpack_mant(bus.a_in)),
        .mplier_i (unpack_mant(bus.b_in)),
        .done_o   (mul_done),
        .prod_o   (prod)
    );

    logic signed [9:0] e_n;
    logic [9:0]        shamt;
    logic [MANT_W-1:0] m_n;
    logic              g_n, r_n, s_n, ovf_n, unf_n, grs_n;
    logic [7:0]        er_n;
    logic [25:0]       vec, shv, lost_mask;

    always_comb begin
        e_n = exp_q;
        m_n = prod[46:23];
        g_n = prod[22];
        r_n = prod[21];
        s_n = |prod[20:0];
        if (prod[47]) begin
            m_n = prod[47:24];
            g_n = prod[23];
            r_n = prod[22];
            s_n = |prod[21:0];
            e_n = exp_q + 10'sd1;
        end
        ovf_n     = (e_n >= 10'sd255);
        unf_n     = !ovf_n && (e_n <= 10'sd0);
        er_n      = ovf_n ? 8'hFF : (unf_n ? 8'h00 : e_n[7:0]);
        shamt     = 10'sd1 - e_n;
        vec       = {m_n, g_n, r_n};
        shv       = '0;
        lost_mask = '0;
        // Tiny result: denormalize by 1-E, folding everything shifted out into sticky.
        if (unf_n) begin
            if (shamt >= 10'd26) begin
                s_n = s_n | (|vec);
                m_n = '0;
                g_n = 1'b0;
                r_n = 1'b0;
            end else begin
                shv       = vec >> shamt[4:0];
                lost_mask = (26'd1 << shamt[4:0]) - 26'd1;
                s_n       = s_n | (|(vec & lost_mask));
                m_n       = shv[25:2];
                g_n       = shv[1];
                r_n       = shv[0];
            end
        end
        grs_n = g_n & (r_n | s_n | m_n[0]);
        if (zero_l_q) begin
            m_n   = '0;
            er_n  = '0;
            grs_n = 1'b0;
            ovf_n = 1'b0;
            unf_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            mr_q <= '0; er_q <= '0; grs_q <= 1'b0; sign_q <= 1'b0;
            zero_q <= 1'b0; inf_q <= 1'b0; nan_q <= 1'b0; ovf_q <= 1'b0; unf_q <= 1'b0;
            sgn_l_q <= 1'b0; zero_l_q <= 1'b0; inf_l_q <= 1'b0; nan_l_q <= 1'b0;
            exp_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    sgn_l_q    <= bus.a_in[31] ^ bus.b_in[31];
                    zero_l_q   <= zero_d;
                    inf_l_q    <= inf_d;
                    nan_l_q    <= nan_d;
                    exp_q      <= exp_d;
                    in_ready_q <= 1'b0;
                    state_q    <= MUL;
                end
                MUL: if (mul_done) state_q <= NORM;
                NORM: begin
                    mr_q <= m_n; er_q <= er_n; grs_q <= grs_n; sign_q <= sgn_l_q;
                    zero_q <= zero_l_q; inf_q <= inf_l_q; nan_q <= nan_l_q;
                    ovf_q <= ovf_n; unf_q <= unf_n;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.Mr_norm    = mr_q;
    assign bus.Er_norm    = er_q;
    assign bus.GRS        = grs_q;
    assign bus.sign_out   = sign_q;
    assign bus.zero_out   = zero_q;
    assign bus.inf_out    = inf_q;
    assign bus.nan_out    = nan_q;
    assign bus.overflow1  = ovf_q;
    assign bus.underflow1 = unf_q;

endmodule

// File: tb/tb_fp32_mul_norm.sv
// Directed bench for fp32_mul_norm: hand-computed vectors, latency, backpressure
// and reset-abort scenarios.
module tb_fp32_mul_norm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fp32_mul_norm_if bus();

    fp32_mul_norm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.a_in = a; bus.b_in = b; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a_in = $urandom;
        bus.b_in = $urandom;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] flags;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        flags = {bus.sign_out, bus.zero_out, bus.inf_out, bus.nan_out,
                 bus.overflow1, bus.underflow1, bus.GRS};
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.Mr_norm !== 24'h0 || bus.Er_norm !== 8'h0) begin
            errs++; $display("FAIL reset_data: Mr=%h Er=%h want 0 0", bus.Mr_norm, bus.Er_norm);
        end
        checks++;
        if (flags !== 7'b0) begin
            errs++; $display("FAIL reset_flags: got %b want 0000000", flags);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_one();
        int lat;
        start_op(32'h3F800000, 32'h3F800000);
        wait_valid(lat);
        checks++;
        if (lat !== 14) begin errs++; $display("FAIL one_latency: got %0d want 14", lat); end
        checks++;
        if (bus.Mr_norm !== 24'h800000 || bus.Er_norm !== 8'd127) begin
            errs++; $display("FAIL one_value: Mr=%h Er=%0d want 800000 127", bus.Mr_norm, bus.Er_norm);
        end
        checks++;
        if (bus.GRS !== 1'b0 || bus.sign_out !== 1'b0 || bus.overflow1 !== 1'b0 || bus.underflow1 !== 1'b0) begin
            errs++; $display("FAIL one_bits: GRS=%b sign=%b ovf=%b unf=%b want 0 0 0 0",
                             bus.GRS, bus.sign_out, bus.overflow1, bus.underflow1);
        end
        finish_op();
    endtask

    task automatic test_backpressure();
        int lat;
        bit bad = 0;
        start_op(32'h3FC00000, 32'hBFC00000);
        wait_valid(lat);
        checks++;
        if (bus.Mr_norm !== 24'h900000 || bus.Er_norm !== 8'd128 || bus.GRS !== 1'b0 || bus.sign_out !== 1'b1) begin
            errs++; $display("FAIL neg_value: Mr=%h Er=%0d GRS=%b sign=%b want 900000 128 0 1",
                             bus.Mr_norm, bus.Er_norm, bus.GRS, bus.sign_out);
        end
        // Offer new operands while the result is held; they must be ignored.
        bus.a_in = 32'h7F000000; bus.b_in = 32'h7F000000; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.Mr_norm !== 24'h900000 || bus.Er_norm !== 8'd128 || bus.sign_out !== 1'b1)
                bad = 1;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bad) begin
            errs++; $display("FAIL hold_stable: ov=%b ir=%b Mr=%h Er=%0d want 1 0 900000 128",
                             bus.out_valid, bus.in_ready, bus.Mr_norm, bus.Er_norm);
        end
        finish_op();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errs++; $display("FAIL handshake: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'h7F000000, 32'h7F000000);
        wait_valid(lat);
        checks++;
        if (lat !== 14 || bus.overflow1 !== 1'b1 || bus.Er_norm !== 8'hFF) begin
            errs++; $display("FAIL overflow: lat=%0d ovf=%b Er=%h want 14 1 ff", lat, bus.overflow1, bus.Er_norm);
        end
        finish_op();
        start_op(32'h00800000, 32'h3F000000);
        wait_valid(lat);
        checks++;
        if (lat !== 14 || bus.underflow1 !== 1'b1 || bus.Er_norm !== 8'h00 ||
            bus.Mr_norm !== 24'h400000 || bus.GRS !== 1'b0) begin
            errs++; $display("FAIL underflow: lat=%0d unf=%b Er=%h Mr=%h GRS=%b want 14 1 00 400000 0",
                             lat, bus.underflow1, bus.Er_norm, bus.Mr_norm, bus.GRS);
        end
        finish_op();
        start_op(32'h00800000, 32'h00800000);
        wait_valid(lat);
        checks++;
        if (bus.underflow1 !== 1'b1 || bus.Mr_norm !== 24'h0 || bus.GRS !== 1'b0 || bus.Er_norm !== 8'h00) begin
            errs++; $display("FAIL deep_underflow: unf=%b Mr=%h GRS=%b Er=%h want 1 0 0 00",
                             bus.underflow1, bus.Mr_norm, bus.GRS, bus.Er_norm);
        end
        finish_op();
    endtask

    task automatic test_rounding();
        int lat;
        start_op(32'h3F800001, 32'h3FC00000);
        wait_valid(lat);
        checks++;
        if (bus.Mr_norm !== 24'hC00001 || bus.Er_norm !== 8'd127 || bus.GRS !== 1'b1) begin
            errs++; $display("FAIL tie_odd: Mr=%h Er=%0d GRS=%b want c00001 127 1", bus.Mr_norm, bus.Er_norm, bus.GRS);
        end
        finish_op();
        start_op(32'h3F800003, 32'h3FC00000);
        wait_valid(lat);
        checks++;
        if (bus.Mr_norm !== 24'hC00004 || bus.GRS !== 1'b0) begin
            errs++; $display("FAIL tie_even: Mr=%h GRS=%b want c00004 0", bus.Mr_norm, bus.GRS);
        end
        finish_op();
    endtask

    task automatic test_specials();
        int lat;
        start_op(32'h7F800000, 32'h00000000);
        wait_valid(lat);
        checks++;
        if (lat !== 14 || bus.nan_out !== 1'b1 || bus.inf_out !== 1'b0 || bus.zero_out !== 1'b0) begin
            errs++; $display("FAIL nan: lat=%0d nan=%b inf=%b zero=%b want 14 1 0 0",
                             lat, bus.nan_out, bus.inf_out, bus.zero_out);
        end
        finish_op();
        start_op(32'h7F800000, 32'h3F800000);
        wait_valid(lat);
        checks++;
        if (bus.inf_out !== 1'b1 || bus.nan_out !== 1'b0 || bus.zero_out !== 1'b0) begin
            errs++; $display("FAIL inf: inf=%b nan=%b zero=%b want 1 0 0", bus.inf_out, bus.nan_out, bus.zero_out);
        end
        finish_op();
        start_op(32'h00000000, 32'hC0490FDB);
        wait_valid(lat);
        checks++;
        if (bus.zero_out !== 1'b1 || bus.Mr_norm !== 24'h0 || bus.Er_norm !== 8'h0 ||
            bus.GRS !== 1'b0 || bus.underflow1 !== 1'b0 || bus.sign_out !== 1'b1) begin
            errs++; $display("FAIL zero: zero=%b Mr=%h Er=%h GRS=%b unf=%b sign=%b want 1 0 0 0 0 1",
                             bus.zero_out, bus.Mr_norm, bus.Er_norm, bus.GRS, bus.underflow1, bus.sign_out);
        end
        finish_op();
    endtask

    task automatic test_abort();
        int lat;
        bit seen = 0;
        start_op(32'h3FC00000, 32'h3FC00000);
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Mr_norm !== 24'h0) begin
            errs++; $display("FAIL abort_state: in_ready=%b out_valid=%b Mr=%h want 1 0 0",
                             bus.in_ready, bus.out_valid, bus.Mr_norm);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin errs++; $display("FAIL abort_no_valid: got out_valid=1 want 0"); end
        start_op(32'h40000000, 32'h40400000);
        wait_valid(lat);
        checks++;
        if (lat !== 14 || bus.Mr_norm !== 24'hC00000 || bus.Er_norm !== 8'd129) begin
            errs++; $display("FAIL after_abort: lat=%0d Mr=%h Er=%0d want 14 c00000 129", lat, bus.Mr_norm, bus.Er_norm);
        end
        finish_op();
    endtask

    initial begin
        bus.a_in = '0; bus.b_in = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_one();
        test_backpressure();
        test_back_to_back();
        test_rounding();
        test_specials();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/fp32_mul_norm.md
# fp32_mul_norm

Multi-cycle front end of the single-precision multiplier: accepts two IEEE-754 binary32 operands and forms sign, biased exponent and 24×24 mantissa product with an iterative radix-4 shift-add datapath. Normalizes the product and produces the normalized mantissa, exponent and round-up decision consumed directly by the downstream rounding stage. Exception flags for zero, infinity, NaN, overflow and underflow travel alongside for the exception/packing stage.

## Interface
- BIAS, 127: exponent bias.
- MUL_STEPS, 12: radix-4 iterations (24 multiplier bits / 2).
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- a_in  in  32  operand A (binary32).
- b_in  in  32  operand B (binary32).
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE).
- Mr_norm  out  24  normalized mantissa, hidden bit at [23].
- Er_norm  out  8  biased exponent; 0 = subnormal/zero result.
- GRS  out  1  round-up decision (round-to-nearest-even), 1 = add one ulp.
- sign_out  out  1  a_in[31] ^ b_in[31].
- zero_out, inf_out, nan_out  out  1 each  special-operand classification.
- overflow1  out  1  exponent ≥ 255 before rounding.
- underflow1  out  1  result tiny (pre-round exponent ≤ 0).
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.

## Operation
- FSM: IDLE → MUL → NORM → DONE → IDLE.
- IDLE: in_ready=1. On in_valid: latch operands, Ma={e≠0,frac}, Mb likewise (subnormal inputs flush to zero), acc=0, step=0, E=Ea+Eb−BIAS in 10-bit signed; classify: nan if either exp=255 & frac≠0, or inf×zero; inf if either exp=255 (not nan); zero if either exp=0 (not nan/inf). → MUL.
- MUL: each cycle acc += (b[0]?Ma:0) + (b[1]?Ma<<1:0), shifted to the current bit pair; 48-bit accumulator, no truncation. After MUL_STEPS cycles → NORM.
- NORM (one cycle), P=acc[47:0]:
  - P[47]=1: mant=P[47:24], G=P[23], R=P[22], S=|P[21:0], E=E+1.
  - else: mant=P[46:23], G=P[22], R=P[21], S=|P[20:0].
  - E ≥ 255: overflow1=1, Er_norm=8'hFF, mant unchanged.
  - E ≤ 0: underflow1=1, Er_norm=0; shift {mant,G,R} right by 1−E, OR shifted-out bits and R into S; shift ≥ 26 gives mant=0, G=0, S=|all.
  - GRS = G & (R | S | mant[0]).
  - zero_out: Mr_norm=0, Er_norm=0, GRS=0, overflow1=underflow1=0.
- DONE: out_valid=1, outputs stable; on out_ready → IDLE.

## Timing
- Accept at edge T (IDLE, in_valid=1). MUL T+1..T+12, NORM T+13, out_valid=1 from T+14. Fixed latency 14 cycles regardless of operands (specials included).
- Earliest next accept: cycle after out_ready handshake; in_ready=0 in MUL/NORM/DONE.
- in_valid outside IDLE ignored; operand inputs sampled only at accept.
- out_ready while out_valid=0 ignored.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Mr_norm=0, Er_norm=0, GRS=0, sign_out=0, all flags 0.
- rst in any state aborts the operation: next cycle IDLE, outputs at reset values, no out_valid for the aborted op.
- All outputs registered.

## Structure
- Package fp32_pkg: BIAS, EXP_MAX=255, MANT_W=24, PROD_W=48, state enum {IDLE,MUL,NORM,DONE}.
- Sub-module mant_mul_seq: radix-4 iterative 24×24 multiplier (start, done, 48-bit product); FSM, exponent logic and normalization stay in top.

## Test plan
- 0x3F800000 × 0x3F800000 → Mr_norm=0x800000, Er_norm=127, GRS=0, sign_out=0, out_valid exactly 14 cycles after accept.
- 0x3FC00000 × 0xBFC00000 (1.5×−1.5) → Mr_norm=0x900000, Er_norm=128, GRS=0, sign_out=1.
- 0x7F000000 × 0x7F000000 → overflow1=1, Er_norm=0xFF.
- 0x00800000 × 0x3F000000 → underflow1=1, Er_norm=0, Mr_norm=0x400000, GRS=0.
- 0x7F800000 × 0x00000000 → nan_out=1; 0x7F800000 × 0x3F800000 → inf_out=1; 0x00000000 × any finite → zero_out=1, Mr_norm=0.
- out_ready low 5 cycles after out_valid → outputs stable, in_ready=0; rst asserted at MUL cycle 6 → next cycle IDLE, in_ready=1, out_valid=0.
